line_window_cache: RTL
======================

// Module: line_window_cache
// PURPOSE
// Ring buffer of captured GBA lines. It sits directly upstream of the HDMI image generator.
// It stores the incoming GBA pixel stream (already in pxlClk domain) into 4 line slots.
// It serves the 3x3 neighbourhood (prev/cur/next line x prev/cur/next pixel) around the
// pixel index requested by the generator.
// It tells the generator via sameLine whether it may advance to the next GBA line.
// PARAMETERS
// LINEWIDTH  240  pixels per GBA line (index 0..LINEWIDTH-1)
// LINECOUNT  160  lines per GBA frame
// COLORBITS  8    bits per colour channel
// PORTS
// pxlClk                           in   1   pixel clock, sole clock
// rst                              in   1   asynchronous, active-high reset
// pxlInRed, pxlInGreen, pxlInBlue  in   8   write-side pixel data (each)
// pxlInValid                       in   1   write strobe, one pixel per asserted cycle
// newFrameIn                       in   1   write-side frame start pulse, precedes pixel 0 of line 0
// rdFrameStart                     in   1   read-side frame start pulse (HDMI cx==0 && cy==0)
// curPxl                           in   8   requested pixel index, 0..LINEWIDTH-1
// nextLine                         in   1   pulse: reader advances one GBA line
// cacheUpdate                      in   1   pulse once per HDMI line: re-evaluate sameLine
// {prev,cur,next}Line{Prev,Cur,Next}Pxl{Red,Green,Blue}Out  out 8  27 window taps
// sameLine                         out  1   1 = next line not ready, generator must repeat line
// newFrameOut                      out  1   1-cycle pulse when line 0 of a frame completes writing
// overrun                          out  1   sticky: writer pixels were dropped
// BEHAVIOUR
// - Reset: all taps 0; sameLine=1; newFrameOut=0; overrun=0.
//   Write and read line counters, write pixel counter and slot pointers are 0.
//   Reset is honoured mid-line: any partial line is discarded.
// - Write side:
//   - newFrameIn: wrPxl=0, wrLine=0, wrSlot=0, and all line-complete flags are cleared.
//   - pxlInValid: store pixel at (wrSlot, wrPxl), then wrPxl++.
//   - When wrPxl==LINEWIDTH-1 is written: wrPxl=0, mark line complete, wrLine++,
//     wrSlot=(wrSlot+1) mod 4.
//   - Line 0 completion pulses newFrameOut on the next cycle.
//   - After wrLine reaches LINECOUNT, further pixels are dropped without setting overrun
//     until the next newFrameIn.
//   - Overrun guard: the writer may not start line rdLine+3, because that would overwrite
//     slot rdLine-1. Such pixels are dropped and overrun=1. Overrun is cleared only by rst.
//   - newFrameIn and pxlInValid in the same cycle: the frame reset applies, then the pixel
//     is stored as (line 0, pixel 0).
// - Read side:
//   - rdFrameStart: rdLine=0, rdSlot = slot of write line 0.
//   - nextLine: if rdLine<LINECOUNT-1 then rdLine++ and rdSlot=(rdSlot+1) mod 4.
//     At LINECOUNT-1 it is ignored.
//   - rdFrameStart has priority over a simultaneous nextLine.
// - Taps:
//   - Taps are registered, latency 1: the value on cycle n+1 reflects curPxl and rdLine
//     at cycle n.
//   - Line taps: prev=rdLine-1, cur=rdLine, next=rdLine+1 (slots mod 4).
//   - Pixel taps: prev=curPxl-1, cur=curPxl, next=curPxl+1.
//   - Edge clamp: rdLine==0 gives prevLine=cur; rdLine==LINECOUNT-1 gives nextLine=cur.
//     curPxl==0 gives PrevPxl=cur; curPxl>=LINEWIDTH-1 gives NextPxl=pixel LINEWIDTH-1.
//   - curPxl>LINEWIDTH-1 clamps to LINEWIDTH-1.
//   - A tap on a line not yet complete returns that slot's stored contents
//     (stale data is permitted; no X).
// - sameLine:
//   - Registered; updated only on the cycle after cacheUpdate.
//   - Definition: ready(k) = line k complete this frame, or k>=LINECOUNT.
//   - sameLine = !ready(r+2), where r is rdLine after applying any nextLine and
//     rdFrameStart of the same cycle.
//   - Exception: at r>=LINECOUNT-2, sameLine = !ready(LINECOUNT-1).
//   - nextLine and cacheUpdate together (normal case): advance first, then evaluate.
// - Storage: 4 x LINEWIDTH x 3*COLORBITS. Any memory style is acceptable if it meets
//   3 line reads x 3 pixels per cycle at 1-cycle latency.
// TESTING
// - Reset: after rst, check taps=0, sameLine=1, overrun=0, newFrameOut=0.
//   Assert rst mid-line 5 -> counters are 0 and line 5 is not marked complete.
// - Write 3 lines with pixel (x,y) = R=x, G=y, B=0x5A, then cacheUpdate ->
//   sameLine=0 and newFrameOut pulsed once after line 0.
// - Window: rdLine=1, curPxl=10 -> next cycle the taps read R=9/10/11 and G=0/1/2.
//   curPxl=0 -> PrevPxl R=0. curPxl=239 -> NextPxl R=239.
// - Line edges: rdLine=0 -> prevLine taps equal curLine taps.
//   Step nextLine 159 times -> rdLine=159, nextLine taps equal curLine taps.
//   A further nextLine is ignored.
// - Stall: stop writing after line 2 while reading line 0, then nextLine+cacheUpdate ->
//   rdLine=1, sameLine=1. Complete line 3 and pulse cacheUpdate -> sameLine=0.
// - Overrun: keep rdLine=0 and write lines 0-2 plus 5 pixels of line 3 ->
//   overrun=1, slot of line 0 is unchanged, overrun stays 1 after newFrameIn.

Source files
------------

// File: rtl/line_window_cache.sv
// line_window_cache: four-slot ring of captured GBA lines. It serves a registered 3x3 RGB
// neighbourhood around the requested pixel and tells the HDMI generator whether the next
// GBA line is ready. Line y always lives in slot y mod 4 because the write slot restarts at 0
// on every frame start and steps with the line counter.
module line_window_cache #(
    parameter int unsigned LINEWIDTH = 240,
    parameter int unsigned LINECOUNT = 160,
    parameter int unsigned COLORBITS = 8
) (
    input  logic                 pxlClk,
    input  logic                 rst,
    input  logic [COLORBITS-1:0] pxlInRed,
    input  logic [COLORBITS-1:0] pxlInGreen,
    input  logic [COLORBITS-1:0] pxlInBlue,
    input  logic                 pxlInValid,
    input  logic                 newFrameIn,
    input  logic                 rdFrameStart,
    input  logic [7:0]           curPxl,
    input  logic                 nextLine,
    input  logic                 cacheUpdate,
    output logic [COLORBITS-1:0] prevLinePrevPxlRedOut,
    output logic [COLORBITS-1:0] prevLinePrevPxlGreenOut,
    output logic [COLORBITS-1:0] prevLinePrevPxlBlueOut,
    output logic [COLORBITS-1:0] prevLineCurPxlRedOut,
    output logic [COLORBITS-1:0] prevLineCurPxlGreenOut,
    output logic [COLORBITS-1:0] prevLineCurPxlBlueOut,
    output logic [COLORBITS-1:0] prevLineNextPxlRedOut,
    output logic [COLORBITS-1:0] prevLineNextPxlGreenOut,
    output logic [COLORBITS-1:0] prevLineNextPxlBlueOut,
    output logic [COLORBITS-1:0] curLinePrevPxlRedOut,
    output logic [COLORBITS-1:0] curLinePrevPxlGreenOut,
    output logic [COLORBITS-1:0] curLinePrevPxlBlueOut,
    output logic [COLORBITS-1:0] curLineCurPxlRedOut,
    output logic [COLORBITS-1:0] curLineCurPxlGreenOut,
    output logic [COLORBITS-1:0] curLineCurPxlBlueOut,
    output logic [COLORBITS-1:0] curLineNextPxlRedOut,
    output logic [COLORBITS-1:0] curLineNextPxlGreenOut,
    output logic [COLORBITS-1:0] curLineNextPxlBlueOut,
    output logic [COLORBITS-1:0] nextLinePrevPxlRedOut,
    output logic [COLORBITS-1:0] nextLinePrevPxlGreenOut,
    output logic [COLORBITS-1:0] nextLinePrevPxlBlueOut,
    output logic [COLORBITS-1:0] nextLineCurPxlRedOut,
    output logic [COLORBITS-1:0] nextLineCurPxlGreenOut,
    output logic [COLORBITS-1:0] nextLineCurPxlBlueOut,
    output logic [COLORBITS-1:0] nextLineNextPxlRedOut,
    output logic [COLORBITS-1:0] nextLineNextPxlGreenOut,
    output logic [COLORBITS-1:0] nextLineNextPxlBlueOut,
    output logic                 sameLine,
    output logic                 newFrameOut,
    output logic                 overrun
);

    localparam int unsigned PW = 3 * COLORBITS;
    localparam int unsigned LW = $clog2(LINECOUNT + 1);
    localparam int unsigned XW = 8;
    localparam logic [XW-1:0] LastPxl  = XW'(LINEWIDTH - 1);
    localparam logic [LW-1:0] LastLine = LW'(LINECOUNT - 1);
    localparam logic [LW-1:0] NumLines = LW'(LINECOUNT);
    localparam logic [LW-1:0] LateLine = LW'(LINECOUNT - 2);

    logic [PW-1:0] mem [4][LINEWIDTH];

    logic [XW-1:0] wr_pxl_q, fr_pxl;
    logic [LW-1:0] wr_line_q, fr_line;
    logic [LW-1:0] rd_line_q, rd_line_d, ready_line;
    logic          wr_live, wr_blocked, wr_en, line_end;
    logic          same_line_q, new_frame_q, overrun_q;
    logic [1:0]    line_slot [3];
    logic [XW-1:0] pxl_idx [3];
    logic [XW-1:0] pxl_clamp;
    logic [PW-1:0] tap_q [3][3];

    // Write-side decode; a frame start in the same cycle applies before the pixel.
    always_comb begin
        fr_pxl     = newFrameIn ? '0 : wr_pxl_q;
        fr_line    = newFrameIn ? '0 : wr_line_q;
        wr_live    = pxlInValid && (fr_line < NumLines);
        // Starting line rdLine+3 would land in the slot still holding rdLine-1.
        wr_blocked = ({1'b0, fr_line} >= ({1'b0, rd_line_q} + (LW+1)'(3)));
        wr_en      = wr_live && !wr_blocked;
        line_end   = wr_en && (fr_pxl == LastPxl);
    end

    // Write counters, line-0 completion pulse and sticky overrun flag.
    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) begin
            wr_pxl_q    <= '0;
            wr_line_q   <= '0;
            new_frame_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            new_frame_q <= line_end && (fr_line == '0);
            if (wr_live && wr_blocked) begin
                overrun_q <= 1'b1;
            end
            if (line_end) begin
                wr_pxl_q  <= '0;
                wr_line_q <= fr_line + LW'(1);
            end else begin
                wr_pxl_q  <= wr_en ? fr_pxl + XW'(1) : fr_pxl;
                wr_line_q <= fr_line;
            end
        end
    end

    // Pixel storage; left unreset so stale slot contents are simply served.
    always_ff @(posedge pxlClk) begin
        if (wr_en) begin
            mem[fr_line[1:0]][fr_pxl] <= {pxlInRed, pxlInGreen, pxlInBlue};
        end
    end

    // Read line stepping, readiness target and clamped tap addresses.
    always_comb begin
        if (rdFrameStart) begin
            rd_line_d = '0;
        end else if (nextLine && (rd_line_q < LastLine)) begin
            rd_line_d = rd_line_q + LW'(1);
        end else begin
            rd_line_d = rd_line_q;
        end
        ready_line   = (rd_line_d >= LateLine) ? LastLine : rd_line_d + LW'(2);
        line_slot[0] = (rd_line_q == '0) ? rd_line_q[1:0] : rd_line_q[1:0] - 2'd1;
        line_slot[1] = rd_line_q[1:0];
        line_slot[2] = (rd_line_q == LastLine) ? rd_line_q[1:0] : rd_line_q[1:0] + 2'd1;
        pxl_clamp    = (curPxl > LastPxl) ? LastPxl : curPxl;
        pxl_idx[0]   = (pxl_clamp == '0) ? pxl_clamp : pxl_clamp - XW'(1);
        pxl_idx[1]   = pxl_clamp;
        pxl_idx[2]   = (pxl_clamp == LastPxl) ? pxl_clamp : pxl_clamp + XW'(1);
    end

    // Read line register, sameLine evaluation and the 3x3 tap registers.
    always_ff @(posedge pxlClk or posedge rst) begin
        if (rst) begin
            rd_line_q   <= '0;
            same_line_q <= 1'b1;
            for (int l = 0; l < 3; l++) begin
                for (int p = 0; p < 3; p++) begin
                    tap_q[l][p] <= '0;
                end
            end
        end else begin
            rd_line_q <= rd_line_d;
            if (cacheUpdate) begin
                same_line_q <= !(ready_line < wr_line_q);
            end
            for (int l = 0; l < 3; l++) begin
                for (int p = 0; p < 3; p++) begin
                    tap_q[l][p] <= mem[line_slot[l]][pxl_idx[p]];
                end
            end
        end
    end

    assign sameLine    = same_line_q;
    assign newFrameOut = new_frame_q;
    assign overrun     = overrun_q;

    assign prevLinePrevPxlRedOut   = tap_q[0][0][PW-1 -: COLORBITS];
    assign prevLinePrevPxlGreenOut = tap_q[0][0][2*COLORBITS-1 -: COLORBITS];
    assign prevLinePrevPxlBlueOut  = tap_q[0][0][COLORBITS-1:0];
    assign prevLineCurPxlRedOut    = tap_q[0][1][PW-1 -: COLORBITS];
    assign prevLineCurPxlGreenOut  = tap_q[0][1][2*COLORBITS-1 -: COLORBITS];
    assign prevLineCurPxlBlueOut   = tap_q[0][1][COLORBITS-1:0];
    assign prevLineNextPxlRedOut   = tap_q[0][2][PW-1 -: COLORBITS];
    assign prevLineNextPxlGreenOut = tap_q[0][2][2*COLORBITS-1 -: COLORBITS];
    assign prevLineNextPxlBlueOut  = tap_q[0][2][COLORBITS-1:0];
    assign curLinePrevPxlRedOut    = tap_q[1][0][PW-1 -: COLORBITS];
    assign curLinePrevPxlGreenOut  = tap_q[1][0][2*COLORBITS-1 -: COLORBITS];
    assign curLinePrevPxlBlueOut   = tap_q[1][0][COLORBITS-1:0];
    assign curLineCurPxlRedOut     = tap_q[1][1][PW-1 -: COLORBITS];
    assign curLineCurPxlGreenOut   = tap_q[1][1][2*COLORBITS-1 -: COLORBITS];
    assign curLineCurPxlBlueOut    = tap_q[1][1][COLORBITS-1:0];
    assign curLineNextPxlRedOut    = tap_q[1][2][PW-1 -: COLORBITS];
    assign curLineNextPxlGreenOut  = tap_q[1][2][2*COLORBITS-1 -: COLORBITS];
    assign curLineNextPxlBlueOut   = tap_q[1][2][COLORBITS-1:0];
    assign nextLinePrevPxlRedOut   = tap_q[2][0][PW-1 -: COLORBITS];
    assign nextLinePrevPxlGreenOut = tap_q[2][0][2*COLORBITS-1 -: COLORBITS];
    assign nextLinePrevPxlBlueOut  = tap_q[2][0][COLORBITS-1:0];
    assign nextLineCurPxlRedOut    = tap_q[2][1][PW-1 -: COLORBITS];
    assign nextLineCurPxlGreenOut  = tap_q[2][1][2*COLORBITS-1 -: COLORBITS];
    assign nextLineCurPxlBlueOut   = tap_q[2][1][COLORBITS-1:0];
    assign nextLineNextPxlRedOut   = tap_q[2][2][PW-1 -: COLORBITS];
    assign nextLineNextPxlGreenOut = tap_q[2][2][2*COLORBITS-1 -: COLORBITS];
    assign nextLineNextPxlBlueOut  = tap_q[2][2][COLORBITS-1:0];

endmodule
